// File: rtl/cpu_trace_buffer.sv
// Instruction-trace capture: records {pc, instruction, address} per fetch strobe into a
// circular buffer with PC-match trigger, post-trigger depth, stop-on-full and a valid/ready drain.
module cpu_trace_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_en,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] instruction,
  input  logic [DATA_W-1:0] address,
  input  logic              arm,
  input  logic              mode,
  input  logic              trig_en,
  input  logic [DATA_W-1:0] trig_pc,
  input  logic [CNT_W-1:0]  post_count,
  output logic [1:0]        state,
  output logic              triggered,
  output logic              wrapped,
  output logic [CNT_W-1:0]  count,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_pc,
  output logic [DATA_W-1:0] rd_instr,
  output logic [DATA_W-1:0] rd_addr
);

  localparam int unsigned    AW      = $clog2(DEPTH);
  localparam int unsigned    EW      = 3 * DATA_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [AW-1:0]    PONE_C  = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] post_q, post_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [CNT_W-1:0] rd_left_q, rd_left_d;
  logic             triggered_q, triggered_d;
  logic             wrapped_q, wrapped_d;
  logic             rd_valid_q, rd_valid_d;
  logic             load_q, load_d;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [EW-1:0]    rd_entry;
  logic             wr_en;
  logic             hit;

  assign wr_en = cap_en && !arm && ((state_q == S_ARMED) || (state_q == S_POST));
  assign hit   = trig_en && (pc == trig_pc);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    post_d      = post_q;
    remain_d    = remain_q;
    rd_left_d   = rd_left_q;
    triggered_d = triggered_q;
    wrapped_d   = wrapped_q;
    rd_valid_d  = rd_valid_q;
    load_d      = 1'b0;

    if (arm) begin
      state_d     = S_ARMED;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      rd_left_d   = '0;
      triggered_d = 1'b0;
      wrapped_d   = 1'b0;
      rd_valid_d  = 1'b0;
      post_d      = (post_count > LAST_C) ? LAST_C : post_count;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PONE_C;
        if (count_q == DEPTH_C) begin
          wrapped_d = 1'b1;
        end else begin
          count_d = count_q + ONE_C;
        end
        // Trigger outranks stop-on-full when both land on the same write.
        if (state_q == S_ARMED) begin
          if (hit) begin
            triggered_d = 1'b1;
            if (post_q == '0) begin
              state_d = S_DONE;
              load_d  = 1'b1;
            end else begin
              state_d  = S_POST;
              remain_d = post_q;
            end
          end else if (mode && (count_q == LAST_C)) begin
            state_d = S_DONE;
            load_d  = 1'b1;
          end
        end else begin
          remain_d = remain_q - ONE_C;
          if (remain_q == ONE_C) begin
            state_d = S_DONE;
            load_d  = 1'b1;
          end
        end
      end

      // Read port is set up one cycle after the final write, from the settled pointers.
      if (load_q) begin
        rd_ptr_d   = wrapped_q ? wr_ptr_q : '0;
        rd_left_d  = count_q;
        rd_valid_d = (count_q != '0);
      end else if (rd_valid_q && rd_ready) begin
        rd_ptr_d   = rd_ptr_q + PONE_C;
        rd_left_d  = rd_left_q - ONE_C;
        rd_valid_d = (rd_left_q != ONE_C);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      post_q      <= '0;
      remain_q    <= '0;
      rd_left_q   <= '0;
      triggered_q <= 1'b0;
      wrapped_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      post_q      <= post_d;
      remain_q    <= remain_d;
      rd_left_q   <= rd_left_d;
      triggered_q <= triggered_d;
      wrapped_q   <= wrapped_d;
      rd_valid_q  <= rd_valid_d;
      load_q      <= load_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {pc, instruction, address};
    end
  end

  assign rd_entry  = mem_q[rd_ptr_q];
  assign state     = state_q;
  assign triggered = triggered_q;
  assign wrapped   = wrapped_q;
  assign count     = count_q;
  assign rd_valid  = rd_valid_q;
  assign rd_pc     = rd_valid_q ? rd_entry[EW-1 -: DATA_W]         : '0;
  assign rd_instr  = rd_valid_q ? rd_entry[2*DATA_W-1 -: DATA_W]   : '0;
  assign rd_addr   = rd_valid_q ? rd_entry[DATA_W-1:0]             : '0;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: table of capture scenarios drained against a
// scoreboard of expected entries, plus hand sequences for backpressure, re-arm and async reset.
module tb_cpu_trace_buffer;

  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cap_en = 1'b0;
  logic [DW-1:0] pc = '0, instruction = '0, address = '0;
  logic          arm = 1'b0, mode = 1'b0, trig_en = 1'b0;
  logic [DW-1:0] trig_pc = '0;
  logic [CW-1:0] post_count = '0;
  logic [1:0]    state;
  logic          triggered, wrapped, rd_valid;
  logic          rd_ready = 1'b0;
  logic [CW-1:0] count;
  logic [DW-1:0] rd_pc, rd_instr, rd_addr;

  cpu_trace_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cap_en(cap_en), .pc(pc), .instruction(instruction),
    .address(address), .arm(arm), .mode(mode), .trig_en(trig_en), .trig_pc(trig_pc),
    .post_count(post_count), .state(state), .triggered(triggered), .wrapped(wrapped),
    .count(count), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc),
    .rd_instr(rd_instr), .rd_addr(rd_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] pc;
    logic [DW-1:0] instr;
    logic [DW-1:0] addr;
  } entry_t;

  typedef struct {
    bit            mode;
    bit            trig_en;
    logic [DW-1:0] trig_pc;
    logic [CW-1:0] post;
    int unsigned   n;
    int unsigned   mid_at;
    logic [1:0]    mid_state;
    logic          exp_trig;
    logic          exp_wrap;
    logic [CW-1:0] exp_count;
    logic [DW-1:0] exp_first_pc;
    bit            extra;
  } vec_t;

  entry_t sb[$];
  vec_t   vecs[3];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input bit m, input bit te, input logic [DW-1:0] tp, input logic [CW-1:0] pcnt);
    mode = m; trig_en = te; trig_pc = tp; post_count = pcnt;
    arm = 1'b1; cap_en = 1'b1;
    tick;
    arm = 1'b0; cap_en = 1'b0;
    sb.delete();
  endtask

  task automatic fetch(input int unsigned i, input bit captured);
    entry_t e;
    e.pc = 32'(i * 4);
    e.instr = 32'hA500_0000 ^ 32'(i * 32'h0101);
    e.addr = 32'h8000_0000 + 32'(i * 8);
    cap_en = 1'b1; pc = e.pc; instruction = e.instr; address = e.addr;
    tick;
    cap_en = 1'b0;
    if (captured) begin
      sb.push_back(e);
      if (sb.size() > DEPTH) void'(sb.pop_front());
    end
  endtask

  task automatic drain(input int unsigned max_cycles);
    entry_t e;
    rd_ready = 1'b1;
    for (int unsigned c = 0; c < max_cycles && sb.size() > 0; c++) begin
      if (rd_valid) begin
        e = sb.pop_front();
        check("rd_pc", rd_pc, e.pc);
        check("rd_instr", rd_instr, e.instr);
        check("rd_addr", rd_addr, e.addr);
      end
      tick;
    end
    check("drain_left", sb.size(), 0);
    check("rd_valid_after_drain", rd_valid, 1'b0);
    rd_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h40, 5'd3, 20, 17, 2'd2, 1'b1, 1'b1, 5'd16, 32'h10, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h08, 5'd0, 3, 2, 2'd1, 1'b1, 1'b0, 5'd3, 32'h00, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h08, 5'd0, 16, 15, 2'd1, 1'b0, 1'b0, 5'd16, 32'h00, 1'b1};

    // Reset and IDLE behaviour
    tick; tick;
    rst = 1'b1;
    check("reset_state", state, 2'd0);
    check("reset_count", count, 0);
    check("reset_rd_valid", rd_valid, 1'b0);
    check("reset_triggered", triggered, 1'b0);
    cap_en = 1'b1;
    tick; tick; tick;
    cap_en = 1'b0;
    check("idle_no_write_count", count, 0);
    check("idle_state", state, 2'd0);

    for (int unsigned v = 0; v < 3; v++) begin
      do_arm(vecs[v].mode, vecs[v].trig_en, vecs[v].trig_pc, vecs[v].post);
      check("arm_state", state, 2'd1);
      check("arm_count", count, 0);
      for (int unsigned i = 0; i < vecs[v].n; i++) begin
        fetch(i, 1'b1);
        if (i + 1 == vecs[v].mid_at) check("mid_state", state, vecs[v].mid_state);
      end
      check("done_state", state, 2'd3);
      check("done_triggered", triggered, vecs[v].exp_trig);
      check("done_wrapped", wrapped, vecs[v].exp_wrap);
      check("done_count", count, vecs[v].exp_count);
      if (vecs[v].extra) begin
        fetch(vecs[v].n, 1'b0);
        check("ignored_fetch_count", count, vecs[v].exp_count);
        check("ignored_fetch_wrapped", wrapped, 1'b0);
      end
      tick;
      check("load_rd_valid", rd_valid, 1'b1);
      check("first_pc", rd_pc, vecs[v].exp_first_pc);
      drain(2 * DEPTH + 4);
      check("stay_done", state, 2'd3);
    end

    // Backpressure, partial read, then re-arm
    do_arm(1'b1, 1'b0, 32'h0, 5'd0);
    for (int unsigned i = 0; i < DEPTH; i++) fetch(i, 1'b1);
    tick;
    for (int k = 0; k < 5; k++) begin
      check("bp_rd_valid", rd_valid, 1'b1);
      check("bp_rd_pc", rd_pc, sb[0].pc);
      tick;
    end
    rd_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      check("bp_accept_pc", rd_pc, sb[0].pc);
      void'(sb.pop_front());
      tick;
    end
    rd_ready = 1'b0;
    check("bp_third_pc", rd_pc, 32'h08);
    arm = 1'b1;
    tick;
    arm = 1'b0;
    check("rearm_state", state, 2'd1);
    check("rearm_rd_valid", rd_valid, 1'b0);
    check("rearm_count", count, 0);

    // Async reset in the middle of POST
    do_arm(1'b0, 1'b1, 32'h08, 5'd5);
    for (int unsigned i = 0; i < 4; i++) fetch(i, 1'b1);
    check("post_state", state, 2'd2);
    check("post_triggered", triggered, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("async_state", state, 2'd0);
    check("async_count", count, 0);
    check("async_triggered", triggered, 1'b0);
    check("async_rd_valid", rd_valid, 1'b0);
    tick;
    rst = 1'b1;
    tick;
    check("post_reset_idle", state, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
